// File: rtl/snake_game_ctrl_pkg.sv
// Shared encodings and key decoding for the snake game sequencer.
package snake_game_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_W     = 8'h77;
  localparam logic [7:0] KEY_D     = 8'h64;
  localparam logic [7:0] KEY_S     = 8'h73;
  localparam logic [7:0] KEY_A     = 8'h61;
  localparam logic [7:0] KEY_R     = 8'h72;
  // ASCII upper case is lower case with bit 5 cleared
  localparam logic [7:0] CASE_BIT  = 8'h20;

  typedef struct packed {
    logic is_dir;
    dir_t dir;
    logic space;
    logic restart;
  } key_t;

  function automatic key_t decode_key(input logic [7:0] byte_in);
    key_t       k;
    logic [7:0] lc;
    k  = '0;
    // Fold letters to lower case; space is matched on the raw byte
    lc = byte_in | CASE_BIT;
    if (byte_in == KEY_SPACE) begin
      k.space = 1'b1;
    end else if (byte_in[6]) begin
      case (lc)
        KEY_W:   begin k.is_dir = 1'b1; k.dir = DIR_UP;    end
        KEY_D:   begin k.is_dir = 1'b1; k.dir = DIR_RIGHT; end
        KEY_S:   begin k.is_dir = 1'b1; k.dir = DIR_DOWN;  end
        KEY_A:   begin k.is_dir = 1'b1; k.dir = DIR_LEFT;  end
        KEY_R:   k.restart = 1'b1;
        default: k = '0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_dir_fifo.sv
// Small synchronous FIFO of queued move directions (DEPTH must be a power of 2).
module dir_fifo
  import snake_game_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  dir_t din,
  output dir_t head,
  output dir_t tail,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dir_t           mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW-1:0]  tail_idx;

  // Extra pointer MSB distinguishes full from empty
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    tail_idx = wr_ptr[AW-1:0] - AW'(1);
    head     = mem[rd_ptr[AW-1:0]];
    tail     = mem[tail_idx];
  end

  // Storage and pointer update; flush dominates push/pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= DIR_UP;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: key decode, direction queue, frame-paced stepping, game FSM.
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int unsigned BASE_PERIOD   = 30,
  parameter int unsigned MIN_PERIOD    = 4,
  parameter int unsigned SPEEDUP_SHIFT = 2,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter bit          VS_ACTIVE_LOW = 1'b1
) (
  input  logic       px_clk,
  input  logic       rstn,
  input  logic [7:0] dataRX,
  input  logic       WR_RX,
  input  logic       vsync,
  input  logic       collision,
  input  logic [9:0] points,
  output logic [1:0] dir,
  output logic       step,
  output logic       clear_board,
  output logic [1:0] game_state
);

  localparam logic VS_IDLE = VS_ACTIVE_LOW ? 1'b1 : 1'b0;

  state_t     state;
  dir_t       dir_q;
  logic [7:0] cnt;
  logic       vs_q;
  logic       tick;

  key_t       key;
  logic       key_dir;
  logic       key_space;
  logic       key_restart;
  logic [9:0] scaled;
  logic [7:0] sub;
  logic [7:0] period;
  logic       step_now;
  dir_t       ref_dir;
  logic       push;
  logic       pop;
  logic       flush;
  dir_t       fifo_head;
  dir_t       fifo_tail;
  logic       fifo_full;
  logic       fifo_empty;

  assign dir         = dir_q;
  assign game_state  = state;

  // Key decode, gated by the byte-valid strobe
  always_comb begin
    key         = decode_key(dataRX);
    key_dir     = WR_RX && key.is_dir;
    key_space   = WR_RX && key.space;
    key_restart = WR_RX && key.restart;
  end

  // Step period from score, saturating subtraction then floor
  always_comb begin
    scaled = points >> SPEEDUP_SHIFT;
    if (scaled >= 10'(BASE_PERIOD)) sub = '0;
    else                            sub = 8'(BASE_PERIOD) - scaled[7:0];
    period = (sub < 8'(MIN_PERIOD)) ? 8'(MIN_PERIOD) : sub;
  end

  // Queue control: a step is only taken while staying in RUN; pushes compare
  // against the newest queued direction so turns chain correctly
  always_comb begin
    step_now = (state == ST_RUN) && !collision && !key_restart && !key_space &&
               tick && (cnt >= period - 8'd1);
    pop      = step_now && !fifo_empty;
    ref_dir  = fifo_empty ? dir_q : fifo_tail;
    push     = (state == ST_RUN) && !collision && !key_restart && !key_space &&
               key_dir && (key.dir != ref_dir) &&
               (key.dir != dir_t'(ref_dir ^ 2'd2)) && !fifo_full;
    flush    = ((state == ST_RUN) && (collision || key_restart)) ||
               (((state == ST_PAUSE) || (state == ST_OVER)) && key_restart);
  end

  dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (px_clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (key.dir),
    .head  (fifo_head),
    .tail  (fifo_tail),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Registered vsync edge detect: tick one cycle after the active-going edge
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      vs_q <= VS_IDLE;
      tick <= 1'b0;
    end else begin
      vs_q <= vsync;
      tick <= (vs_q == VS_IDLE) && (vsync != VS_IDLE);
    end
  end

  // Game FSM with frame counter and registered pulse outputs
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      step        <= 1'b0;
      clear_board <= 1'b0;
      cnt         <= '0;
    end else begin
      step        <= 1'b0;
      clear_board <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_dir) begin
            state       <= ST_RUN;
            dir_q       <= key.dir;
            clear_board <= 1'b1;
            cnt         <= '0;
          end
        end
        ST_RUN: begin
          if (collision) begin
            state <= ST_OVER;
          end else if (key_restart) begin
            state       <= ST_IDLE;
            clear_board <= 1'b1;
          end else if (key_space) begin
            state <= ST_PAUSE;
          end else if (tick) begin
            if (step_now) begin
              cnt  <= '0;
              step <= 1'b1;
              if (!fifo_empty) dir_q <= fifo_head;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ST_PAUSE: begin
          if (key_restart) begin
            state       <= ST_IDLE;
            clear_board <= 1'b1;
          end else if (key_space) begin
            state <= ST_RUN;
          end
        end
        ST_OVER: begin
          if (key_restart) begin
            state       <= ST_IDLE;
            clear_board <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for the snake game sequencer.
module tb_snake_game_ctrl;

  logic       px_clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] dataRX = 8'h00;
  logic       WR_RX = 1'b0;
  logic       vsync = 1'b1;
  logic       collision = 1'b0;
  logic [9:0] points = 10'd0;
  logic [1:0] dir;
  logic       step;
  logic       clear_board;
  logic [1:0] game_state;

  int n_checks = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int clr_cnt  = 0;
  logic [1:0] step_dir = 2'd0;
  int s0, c0;

  snake_game_ctrl dut (
    .px_clk      (px_clk),
    .rstn        (rstn),
    .dataRX      (dataRX),
    .WR_RX       (WR_RX),
    .vsync       (vsync),
    .collision   (collision),
    .points      (points),
    .dir         (dir),
    .step        (step),
    .clear_board (clear_board),
    .game_state  (game_state)
  );

  always #5 px_clk = ~px_clk;

  // Pulse counters sampled away from the active edge
  always @(negedge px_clk) begin
    if (step) begin
      step_cnt = step_cnt + 1;
      step_dir = dir;
    end
    if (clear_board) clr_cnt = clr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_key(input logic [7:0] b);
    dataRX = b;
    WR_RX  = 1'b1;
    @(negedge px_clk);
    WR_RX  = 1'b0;
    dataRX = 8'h00;
    @(negedge px_clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b0;
      repeat (3) @(negedge px_clk);
      vsync = 1'b1;
      repeat (3) @(negedge px_clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge px_clk);
    check("rst_dir", 32'(dir), 32'd1);
    check("rst_step", 32'(step), 32'd0);
    check("rst_clr", 32'(clear_board), 32'd0);
    check("rst_state", 32'(game_state), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge px_clk);

    // 1: start with 'd', step every 30 frames at points=0
    send_key(8'h64);
    check("start_clr", 32'(clr_cnt), 32'd1);
    check("start_state", 32'(game_state), 32'd1);
    check("start_dir", 32'(dir), 32'd1);
    frames(29);
    check("p30_before", 32'(step_cnt), 32'd0);
    frames(1);
    check("p30_step1", 32'(step_cnt), 32'd1);
    frames(30);
    check("p30_step2", 32'(step_cnt), 32'd2);

    // 2: queued turns, third key dropped on full queue
    send_key(8'h77);
    send_key(8'h61);
    send_key(8'h73);
    check("q_dir_held", 32'(dir), 32'd1);
    frames(30);
    check("q_step3", 32'(step_cnt), 32'd3);
    check("q_first", 32'(step_dir), 32'd0);
    frames(30);
    check("q_second", 32'(step_dir), 32'd3);
    frames(30);
    check("q_drop", 32'(step_dir), 32'd3);

    // 3: reversal and same-direction keys rejected (dir is LEFT here)
    send_key(8'h64);
    send_key(8'h41);
    frames(30);
    check("rej_steps", 32'(step_cnt), 32'd6);
    check("rej_dir", 32'(step_dir), 32'd3);
    check("rej_state", 32'(game_state), 32'd1);

    // 4: speed scaling; period drop below count steps on next tick
    frames(10);
    points = 10'd200;
    s0 = step_cnt;
    frames(1);
    check("pdrop_step", 32'(step_cnt - s0), 32'd1);
    frames(3);
    check("p4_before", 32'(step_cnt - s0), 32'd1);
    frames(1);
    check("p4_step", 32'(step_cnt - s0), 32'd2);
    points = 10'd40;
    frames(19);
    check("p20_before", 32'(step_cnt - s0), 32'd2);
    frames(1);
    check("p20_step", 32'(step_cnt - s0), 32'd3);

    // 5: pause holds count; resume continues from it
    frames(5);
    send_key(8'h20);
    check("pause_state", 32'(game_state), 32'd2);
    s0 = step_cnt;
    frames(100);
    check("pause_nostep", 32'(step_cnt - s0), 32'd0);
    send_key(8'h20);
    check("resume_state", 32'(game_state), 32'd1);
    frames(14);
    check("resume_before", 32'(step_cnt - s0), 32'd0);
    frames(1);
    check("resume_step", 32'(step_cnt - s0), 32'd1);

    // 6: collision beats 'r' on a would-be step tick; queued key flushed
    send_key(8'h77);
    frames(19);
    s0 = step_cnt;
    c0 = clr_cnt;
    vsync = 1'b0;
    @(negedge px_clk);
    collision = 1'b1;
    dataRX    = 8'h72;
    WR_RX     = 1'b1;
    @(negedge px_clk);
    collision = 1'b0;
    WR_RX     = 1'b0;
    dataRX    = 8'h00;
    vsync     = 1'b1;
    repeat (3) @(negedge px_clk);
    check("over_state", 32'(game_state), 32'd3);
    check("over_nostep", 32'(step_cnt - s0), 32'd0);
    check("over_noclr", 32'(clr_cnt - c0), 32'd0);
    send_key(8'h52);
    check("restart_state", 32'(game_state), 32'd0);
    check("restart_clr", 32'(clr_cnt - c0), 32'd1);
    send_key(8'h73);
    check("rerun_dir", 32'(dir), 32'd2);
    frames(20);
    check("flush_step", 32'(step_cnt - s0), 32'd1);
    check("flush_dir", 32'(step_dir), 32'd2);

    // Async reset mid-RUN with a queued key
    send_key(8'h64);
    frames(3);
    @(negedge px_clk);
    #1 rstn = 1'b0;
    #1;
    check("arst_dir", 32'(dir), 32'd1);
    check("arst_state", 32'(game_state), 32'd0);
    check("arst_step", 32'(step), 32'd0);
    check("arst_clr", 32'(clear_board), 32'd0);
    repeat (2) @(negedge px_clk);
    rstn = 1'b1;
    @(negedge px_clk);
    send_key(8'h77);
    s0 = step_cnt;
    frames(20);
    check("arst_step_cnt", 32'(step_cnt - s0), 32'd1);
    check("arst_fifo_empty", 32'(step_dir), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
